// File: rtl/mfcc_frame_stacker.sv
// mfcc_frame_stacker: collects MFCC coefficient frames into a ring of NFRAMES+1 slots
// and serves the newest NFRAMES complete frames as a DNN context window.
//
// Optional feature: define MFCC_SAT_EN to saturate stored values to 16 bits;
// otherwise the shifted coefficient wraps to its low 16 bits.
//
// Ports:
//   clk, rst_n          clock (posedge), asynchronous active-low reset
//   flush               synchronous clear of all window state
//   dv_in/idx_in/x_in   coefficient stream: valid, index, signed 26-bit value
//   rd_en/rd_frame/rd_coef  read request: frame age (0 = newest), coefficient
//   rd_data/rd_valid    read result, one cycle after rd_en
//   frame_done          pulse per completed frame
//   stack_valid         high once NFRAMES frames are held
//   frame_cnt           wrapping completed-frame counter
//   seq_err             pulse on an out-of-sequence index
module mfcc_frame_stacker #(
   parameter int NFRAMES = 11,
   parameter int NCOEF   = 12,
   parameter int SHIFT   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        dv_in,
   input  logic [4:0]  idx_in,
   input  logic [25:0] x_in,
   input  logic        rd_en,
   input  logic [3:0]  rd_frame,
   input  logic [3:0]  rd_coef,
   output logic [15:0] rd_data,
   output logic        rd_valid,
   output logic        frame_done,
   output logic        stack_valid,
   output logic [15:0] frame_cnt,
   output logic        seq_err
);
   localparam int NS = NFRAMES + 1;

   logic [15:0]        mem [NS*16];
   logic [3:0]         head, wslot, fill, exp_idx, fill_n, rslot;
   logic signed [25:0] shifted;
   logic [15:0]        wval;
   logic [4:0]         diff;
   logic               hit, restart, last, we;

   always_comb begin
      shifted = $signed(x_in) >>> SHIFT;
`ifdef MFCC_SAT_EN
      wval = shifted > 26'sd32767 ? 16'h7fff : shifted < -26'sd32768 ? 16'h8000 : shifted[15:0];
`else
      wval = shifted[15:0];
`endif
      // exp_idx never reaches NCOEF, so any idx_in >= NCOEF fails the match
      hit     = dv_in && idx_in == {1'b0, exp_idx};
      restart = dv_in && !hit && idx_in == 5'd0;
      last    = hit && idx_in == 5'(NCOEF - 1);
      we      = !flush && (hit || restart);
      fill_n  = fill == 4'(NFRAMES) ? fill : fill + 1'b1;
      // (head - rd_frame) mod NS; out-of-window ages are masked by the fill check
      diff    = {1'b0, head} - {1'b0, rd_frame};
      rslot   = diff[4] ? 4'(diff + 5'(NS)) : diff[3:0];
   end

   // writes only ever target the spare slot, never a visible frame
   always_ff @(posedge clk)
      if (we) mem[{wslot, idx_in[3:0]}] <= wval;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data     <= '0;
         rd_valid    <= 1'b0;
         frame_done  <= 1'b0;
         stack_valid <= 1'b0;
         frame_cnt   <= '0;
         seq_err     <= 1'b0;
         head        <= '0;
         wslot       <= 4'd1;
         fill        <= '0;
         exp_idx     <= '0;
      end else if (flush) begin
         rd_data     <= '0;
         rd_valid    <= 1'b0;
         frame_done  <= 1'b0;
         stack_valid <= 1'b0;
         frame_cnt   <= '0;
         seq_err     <= 1'b0;
         head        <= '0;
         wslot       <= 4'd1;
         fill        <= '0;
         exp_idx     <= '0;
      end else begin
         rd_valid   <= rd_en;
         if (rd_en)
            rd_data <= (rd_frame >= fill || {1'b0, rd_coef} >= 5'(NCOEF)) ? '0 : mem[{rslot, rd_coef}];
         frame_done <= last;
         seq_err    <= dv_in && !hit;
         if (hit)
            exp_idx <= last ? '0 : exp_idx + 1'b1;
         else if (dv_in)
            exp_idx <= restart ? 4'd1 : 4'd0;
         if (last) begin
            head        <= wslot;
            wslot       <= wslot == 4'(NFRAMES) ? '0 : wslot + 1'b1;
            fill        <= fill_n;
            stack_valid <= fill_n == 4'(NFRAMES);
            frame_cnt   <= frame_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mfcc_frame_stacker.sv
// tb_mfcc_frame_stacker: self-checking bench for mfcc_frame_stacker using a
// frame-history model, a read scoreboard and a table of read vectors.
module tb_mfcc_frame_stacker;
   localparam int NF = 11;
   localparam int NC = 12;

   logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, dv_in = 1'b0, rd_en = 1'b0;
   logic [4:0]  idx_in = '0;
   logic [25:0] x_in = '0;
   logic [3:0]  rd_frame = '0, rd_coef = '0;
   logic [15:0] rd_data, frame_cnt;
   logic        rd_valid, frame_done, stack_valid, seq_err;

   always #5 clk = ~clk;

   mfcc_frame_stacker dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .dv_in(dv_in), .idx_in(idx_in),
      .x_in(x_in), .rd_en(rd_en), .rd_frame(rd_frame), .rd_coef(rd_coef),
      .rd_data(rd_data), .rd_valid(rd_valid), .frame_done(frame_done),
      .stack_valid(stack_valid), .frame_cnt(frame_cnt), .seq_err(seq_err)
   );

   typedef logic [15:0] frame_t [NC];
   typedef struct { logic v; logic [15:0] d; } exp_t;
   typedef struct { logic en; logic [3:0] f; logic [3:0] c; logic v; logic [15:0] d; } vec_t;

   int     checks = 0, errors = 0, cnt = 0;
   frame_t hist[$];
   frame_t cur;
   exp_t   sb[$];
   vec_t   tab[12];

`ifdef MFCC_SAT_EN
   localparam logic [15:0] POS_BIG = 16'h7fff, NEG_BIG = 16'h8000;
`else
   localparam logic [15:0] POS_BIG = 16'hffff, NEG_BIG = 16'h0000;
`endif

   function automatic logic [15:0] stored(input logic [25:0] x);
      logic signed [25:0] xs;
      int v;
      xs = x;
      v  = xs;
      v  = v >>> 8;
`ifdef MFCC_SAT_EN
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
`endif
      return v[15:0];
   endfunction

   function automatic logic [15:0] exp_rd(input int k, input int c);
      int fill;
      fill = hist.size() < NF ? hist.size() : NF;
      if (k >= fill || c >= NC) return 16'h0;
      return hist[hist.size() - 1 - k][c];
   endfunction

   task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   task automatic pop_chk(input string n);
      exp_t e;
      e = sb.pop_front();
      chk({n, "_valid"}, {15'b0, rd_valid}, {15'b0, e.v});
      chk(n, rd_data, e.d);
   endtask

   task automatic send(input int i, input logic [25:0] x);
      dv_in  = 1'b1;
      idx_in = 5'(i);
      x_in   = x;
      @(negedge clk);
      dv_in  = 1'b0;
   endtask

   task automatic send_frame(input int f, input int mode, input logic err0);
      logic [25:0] x;
      for (int c = 0; c < NC; c++) begin
         x = mode == 0 ? 26'(f * 256 + c) : 26'((f * 16 + c) << 8);
         cur[c] = stored(x);
         send(c, x);
         if (c == 0) chk("seq_err_first", {15'b0, seq_err}, {15'b0, err0});
      end
      hist.push_back(cur);
      cnt++;
      chk("frame_done", {15'b0, frame_done}, 16'd1);
      chk("frame_cnt", frame_cnt, 16'(cnt));
   endtask

   task automatic rd(input int k, input int c);
      sb.push_back('{1'b1, exp_rd(k, c)});
      rd_en    = 1'b1;
      rd_frame = 4'(k);
      rd_coef  = 4'(c);
      @(negedge clk);
      rd_en    = 1'b0;
      pop_chk("rd");
   endtask

   task automatic chk_zero(input string n);
      chk({n, "_rd_data"}, rd_data, 16'h0);
      chk({n, "_rd_valid"}, {15'b0, rd_valid}, 16'h0);
      chk({n, "_frame_done"}, {15'b0, frame_done}, 16'h0);
      chk({n, "_stack_valid"}, {15'b0, stack_valid}, 16'h0);
      chk({n, "_frame_cnt"}, frame_cnt, 16'h0);
      chk({n, "_seq_err"}, {15'b0, seq_err}, 16'h0);
   endtask

   initial begin
      // frames g=0..2 stored as g*16+c; newest (age 0) is g=2
      tab[0]  = '{1'b1, 4'd0,  4'd0,  1'b1, 16'd32};
      tab[1]  = '{1'b1, 4'd0,  4'd11, 1'b1, 16'd43};
      tab[2]  = '{1'b1, 4'd1,  4'd5,  1'b1, 16'd21};
      tab[3]  = '{1'b1, 4'd2,  4'd7,  1'b1, 16'd7};
      tab[4]  = '{1'b1, 4'd3,  4'd0,  1'b1, 16'd0};
      tab[5]  = '{1'b1, 4'd0,  4'd12, 1'b1, 16'd0};
      tab[6]  = '{1'b1, 4'd0,  4'd15, 1'b1, 16'd0};
      tab[7]  = '{1'b1, 4'd15, 4'd3,  1'b1, 16'd0};
      tab[8]  = '{1'b1, 4'd1,  4'd11, 1'b1, 16'd27};
      tab[9]  = '{1'b0, 4'd0,  4'd0,  1'b0, 16'd27};
      tab[10] = '{1'b1, 4'd2,  4'd11, 1'b1, 16'd11};
      tab[11] = '{1'b0, 4'd5,  4'd5,  1'b0, 16'd11};

      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // first frame, value = coefficient index
      for (int c = 0; c < NC; c++) begin
         cur[c] = stored(26'(c << 8));
         send(c, 26'(c << 8));
      end
      hist.push_back(cur);
      cnt++;
      chk("f1_done", {15'b0, frame_done}, 16'd1);
      chk("f1_cnt", frame_cnt, 16'd1);
      chk("f1_stack", {15'b0, stack_valid}, 16'd0);
      rd(0, 5);
      chk("f1_done_low", {15'b0, frame_done}, 16'd0);
      rd(1, 5);

      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      hist.delete();
      cnt = 0;
      chk("flush_cnt", frame_cnt, 16'd0);

      for (int f = 0; f < NF; f++) begin
         send_frame(f, 0, 1'b0);
         chk("stack_rise", {15'b0, stack_valid}, {15'b0, f == NF - 1});
      end
      rd(10, 0);
      rd(0, 11);
      rd(5, 3);

      send_frame(11, 0, 1'b0);
      chk("slide_stack", {15'b0, stack_valid}, 16'd1);
      rd(10, 0);
      chk("slide_oldest", rd_data, 16'd1);

      // read of age 0 in the same cycle the next frame completes sees the old head
      for (int c = 0; c < NC - 1; c++) begin
         cur[c] = stored(26'(12 * 256 + c));
         send(c, 26'(12 * 256 + c));
      end
      sb.push_back('{1'b1, exp_rd(0, 0)});
      cur[NC-1] = stored(26'(12 * 256 + NC - 1));
      dv_in = 1'b1; idx_in = 5'(NC - 1); x_in = 26'(12 * 256 + NC - 1);
      rd_en = 1'b1; rd_frame = 4'd0; rd_coef = 4'd0;
      @(negedge clk);
      dv_in = 1'b0; rd_en = 1'b0;
      pop_chk("collide");
      chk("collide_old", rd_data, 16'd11);
      hist.push_back(cur);
      cnt++;
      chk("collide_done", {15'b0, frame_done}, 16'd1);
      rd(0, 0);

      send(0, 26'h100); send(1, 26'h100); send(2, 26'h100); send(5, 26'h100);
      chk("gap_seq_err", {15'b0, seq_err}, 16'd1);
      chk("gap_no_done", {15'b0, frame_done}, 16'd0);
      chk("gap_cnt_hold", frame_cnt, 16'(cnt));
      send_frame(20, 0, 1'b0);
      rd(0, 1);

      send(0, 26'(99 << 8)); send(1, 26'(99 << 8)); send(2, 26'(99 << 8));
      send_frame(21, 0, 1'b1);
      rd(0, 0);
      send(12, 26'h0);
      chk("idx12_err", {15'b0, seq_err}, 16'd1);
      send(3, 26'h0);
      chk("idx3_err", {15'b0, seq_err}, 16'd1);
      rd(0, 0);

      for (int c = 0; c < NC; c++) begin
         x_in = c == 0 ? 26'h1FFFFFF : c == 1 ? 26'h2000000 : 26'(c << 8);
         cur[c] = stored(x_in);
         send(c, x_in);
      end
      hist.push_back(cur);
      cnt++;
      rd(0, 0);
      chk("big_pos", rd_data, POS_BIG);
      rd(0, 1);
      chk("big_neg", rd_data, NEG_BIG);

      // flush wins over a simultaneous read
      sb.push_back('{1'b0, 16'h0});
      flush = 1'b1; rd_en = 1'b1; rd_frame = 4'd0; rd_coef = 4'd0;
      @(negedge clk);
      flush = 1'b0; rd_en = 1'b0;
      hist.delete();
      cnt = 0;
      pop_chk("flush_rd");
      chk("flush_stack", {15'b0, stack_valid}, 16'd0);
      chk("flush_cnt2", frame_cnt, 16'd0);
      rd(0, 0);

      for (int g = 0; g < 3; g++) send_frame(g, 1, 1'b0);
      chk("tab_stack", {15'b0, stack_valid}, 16'd0);
      for (int i = 0; i < 12; i++) begin
         sb.push_back('{tab[i].v, tab[i].d});
         rd_en = tab[i].en; rd_frame = tab[i].f; rd_coef = tab[i].c;
         @(negedge clk);
         pop_chk($sformatf("tab%0d", i));
      end
      rd_en = 1'b0;

      for (int c = 0; c < 5; c++) send(c, 26'h300);
      #2 rst_n = 1'b0;
      #1 chk_zero("async_rst");
      hist.delete();
      cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_frame(5, 1, 1'b0);
      chk("post_rst_stack", {15'b0, stack_valid}, 16'd0);
      rd(0, 3);
      rd(1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
